// File: rtl/id_hazard_ctrl.sv
// ID/EXE writer control: RAW hazard detection against shadowed EXE/MEM/WB
// destinations, stall/bubble/flush generation and saturating statistics counters.
module id_hazard_ctrl #(
    parameter int unsigned ADDR_LEN = 5,
    parameter int unsigned CNT_LEN  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fwd_en,
    input  logic                id_valid,
    input  logic [ADDR_LEN-1:0] id_src1,
    input  logic [ADDR_LEN-1:0] id_src2,
    input  logic                id_uses_src2,
    input  logic [ADDR_LEN-1:0] id_dest,
    input  logic                id_wb_en,
    input  logic                id_mem_r_en,
    input  logic                br_taken,
    output logic                stall,
    output logic                bubble,
    output logic                flush,
    output logic [1:0]          hazard_stage,
    output logic [CNT_LEN-1:0]  stall_cnt,
    output logic [CNT_LEN-1:0]  flush_cnt
);

    typedef struct packed {
        logic                valid;
        logic [ADDR_LEN-1:0] dest;
        logic                wb_en;
        logic                mem_r_en;
    } slot_t;

    slot_t exe_q, mem_q, wb_q;
    slot_t exe_d;

    logic [CNT_LEN-1:0] stall_cnt_q;
    logic [CNT_LEN-1:0] flush_cnt_q;

    logic exe_hit;
    logic mem_hit;
    logic hazard;

    // r0 is hardwired to zero, so it never carries a dependence.
    function automatic logic slot_match(slot_t s, logic [ADDR_LEN-1:0] src);
        return s.valid && s.wb_en && (s.dest == src) && (src != '0);
    endfunction

    always_comb begin
        exe_hit = slot_match(exe_q, id_src1) || (id_uses_src2 && slot_match(exe_q, id_src2));
        mem_hit = slot_match(mem_q, id_src1) || (id_uses_src2 && slot_match(mem_q, id_src2));
        // With forwarding only a load in EXE cannot be bypassed in time.
        if (fwd_en) begin
            hazard = exe_hit && exe_q.mem_r_en;
        end else begin
            hazard = exe_hit || mem_hit;
        end
    end

    always_comb begin
        stall        = 1'b0;
        bubble       = 1'b0;
        flush        = 1'b0;
        hazard_stage = 2'd0;
        if (rst) begin
            bubble = 1'b1;
        end else if (br_taken) begin
            flush  = 1'b1;
            bubble = 1'b1;
        end else if (id_valid && hazard) begin
            stall        = 1'b1;
            bubble       = 1'b1;
            hazard_stage = exe_hit ? 2'd1 : 2'd2;
        end
    end

    always_comb begin
        if (bubble || !id_valid) begin
            exe_d = '0;
        end else begin
            exe_d = '{valid: 1'b1, dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_q       <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= exe_q;
            exe_q <= exe_d;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed self-checking bench for id_hazard_ctrl: hazard modes, r0, branch flush,
// counter saturation and mid-stall reset.
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fwd_en;
    logic        id_valid;
    logic [4:0]  id_src1;
    logic [4:0]  id_src2;
    logic        id_uses_src2;
    logic [4:0]  id_dest;
    logic        id_wb_en;
    logic        id_mem_r_en;
    logic        br_taken;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [1:0]  hazard_stage;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    id_hazard_ctrl #(.ADDR_LEN(5), .CNT_LEN(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .fwd_en       (fwd_en),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_uses_src2 (id_uses_src2),
        .id_dest      (id_dest),
        .id_wb_en     (id_wb_en),
        .id_mem_r_en  (id_mem_r_en),
        .br_taken     (br_taken),
        .stall        (stall),
        .bubble       (bubble),
        .flush        (flush),
        .hazard_stage (hazard_stage),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Combinational outputs packed as {stall, bubble, flush, hazard_stage}.
    task automatic chk_out(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, stall, bubble, flush, hazard_stage}, {27'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic u2, input logic [4:0] d, input logic wb, input logic ld);
        id_valid     = v;
        id_src1      = s1;
        id_src2      = s2;
        id_uses_src2 = u2;
        id_dest      = d;
        id_wb_en     = wb;
        id_mem_r_en  = ld;
        #1;
    endtask

    task automatic drain();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; fwd_en = 1'b0; br_taken = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk_out("reset_outputs", 5'b01000);
        tick(); tick();
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_flush_cnt", flush_cnt, 0);
        rst = 1'b0;
        #1;
        chk_out("idle_outputs", 5'b00000);

        // No forwarding: ADD r3 then SUB reading r3 -> stall EXE, stall MEM, issue.
        issue(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
        chk_out("nofwd_add_issue", 5'b00000);
        tick();
        issue(1'b1, 5'd3, 5'd2, 1'b0, 5'd6, 1'b1, 1'b0);
        chk_out("nofwd_stall_exe", 5'b11001);
        tick();
        chk_out("nofwd_stall_mem", 5'b11010);
        tick();
        chk_out("nofwd_sub_issue", 5'b00000);
        chk("nofwd_stall_cnt", stall_cnt, 2);
        tick();
        drain();

        // Forwarding: load-use on src2 costs one cycle.
        fwd_en = 1'b1;
        issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        issue(1'b1, 5'd2, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0);
        chk_out("fwd_loaduse_stall", 5'b11001);
        tick();
        chk_out("fwd_loaduse_release", 5'b00000);
        tick();
        chk("fwd_stall_cnt", stall_cnt, 3);
        drain();

        // Same pair but src2 not read: no stall.
        issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        issue(1'b1, 5'd2, 5'd4, 1'b0, 5'd8, 1'b1, 1'b0);
        chk_out("fwd_src2_unused", 5'b00000);
        tick();
        drain();

        // Forwarding: ALU result dependence never stalls.
        issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd5, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);
        chk_out("fwd_alu_dep_exe", 5'b00000);
        tick();
        issue(1'b1, 5'd5, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        chk_out("fwd_alu_dep_mem", 5'b00000);
        tick();
        drain();

        // r0 never creates a hazard.
        fwd_en = 1'b0;
        issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        issue(1'b1, 5'd0, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0);
        chk_out("r0_nofwd", 5'b00000);
        fwd_en = 1'b1;
        #1;
        chk_out("r0_fwd", 5'b00000);
        drain();

        // Branch taken overrides a load-use hazard.
        issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        issue(1'b1, 5'd9, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        br_taken = 1'b1;
        #1;
        chk_out("br_flush", 5'b01100);
        tick();
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 3);
        br_taken = 1'b0;
        #1;
        chk_out("br_exe_empty", 5'b00000);
        drain();

        // Saturation: preload stall_cnt to FFFE, then three stall cycles.
        fwd_en = 1'b0;
        issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        chk("sat_preload", stall_cnt, 16'hFFFE);
        issue(1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        chk_out("sat_stall1", 5'b11001);
        tick();
        chk("sat_cnt1", stall_cnt, 16'hFFFF);
        chk_out("sat_stall2", 5'b11010);
        tick();
        chk("sat_cnt2", stall_cnt, 16'hFFFF);
        chk_out("sat_issue", 5'b00000);
        tick();
        chk_out("sat_stall3", 5'b11001);
        tick();
        chk("sat_cnt3_nowrap", stall_cnt, 16'hFFFF);
        chk_out("midstall_before_rst", 5'b11010);

        // Reset in the middle of a stall clears slots and counters.
        rst = 1'b1;
        #1;
        chk_out("midstall_rst_out", 5'b01000);
        tick();
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        rst = 1'b0;
        #1;
        chk_out("post_rst_no_hazard", 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
